// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty controller.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        HOLD = 2'd3
    } fade_state_t;

    localparam int DEFAULT_MAX_LEVEL = 10;
    localparam int RESET_LEVEL       = DEFAULT_MAX_LEVEL / 2;

    // Reset level for an arbitrary top level: midpoint, rounded down.
    function automatic int reset_level(input int max_level);
        return max_level / 2;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchronizer, disagreement counter, stable
// register and a one-cycle press pulse on a 0->1 stable transition.
module btn_debounce
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Synchronize, then flip stable only after DEBOUNCE_CYCLES consecutive
    // disagreeing cycles; the press pulse is issued on the flip edge itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_duty_controller.sv
// Duty level controller: debounced inc/dec buttons, saturating level
// register with step pulses, and a triangle auto-fade FSM.
// Optional macro PWM_LOCAL_EN builds a local PWM generator on pwm_out.
module pwm_duty_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_LEVEL       = DEFAULT_MAX_LEVEL,
    parameter int LEVEL_W         = 4,
    parameter int FADE_DIV        = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc_btn,
    input  logic               dec_btn,
    input  logic               fade_en,
    output logic               step_up,
    output logic               step_down,
    output logic [LEVEL_W-1:0] duty_level,
    output logic [1:0]         fade_state,
    output logic               pwm_out
);

    localparam int                 PRESC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [LEVEL_W-1:0] MAX_LVL = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(reset_level(MAX_LEVEL));
    localparam logic [LEVEL_W-1:0] ONE     = LEVEL_W'(1);

    logic               inc_press;
    logic               dec_press;
    fade_state_t        state;
    logic [PRESC_W-1:0] presc;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (inc_btn),
        .press (inc_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (dec_btn),
        .press (dec_press)
    );

    logic fading;
    logic tick;
    logic any_press;
    logic can_up;
    logic can_dn;
    logic man_up;
    logic man_dn;

    assign fading    = (state == UP) || (state == DOWN);
    assign tick      = fading && (presc == PRESC_W'(FADE_DIV - 1));
    assign any_press = inc_press | dec_press;
    assign can_up    = (duty_level != MAX_LVL);
    assign can_dn    = (duty_level != '0);
    // Simultaneous presses cancel each other.
    assign man_up    = inc_press & ~dec_press & can_up;
    assign man_dn    = dec_press & ~inc_press & can_dn;
    assign fade_state = state;

    // Level register, step pulses, fade FSM and prescaler. Manual presses
    // win over fade ticks; a tick coinciding with a press is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            duty_level <= RST_LVL;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            presc      <= '0;
        end else begin
            step_up   <= 1'b0;
            step_down <= 1'b0;

            if (any_press) begin
                if (man_up) begin
                    duty_level <= duty_level + ONE;
                    step_up    <= 1'b1;
                end else if (man_dn) begin
                    duty_level <= duty_level - ONE;
                    step_down  <= 1'b1;
                end
            end else if (tick && fade_en) begin
                if (state == UP) begin
                    if (can_up) begin
                        duty_level <= duty_level + ONE;
                        step_up    <= 1'b1;
                    end
                end else if (can_dn) begin
                    duty_level <= duty_level - ONE;
                    step_down  <= 1'b1;
                end
            end

            // Prescaler only runs while ramping; every other state holds it at 0
            // so entering UP always starts a full FADE_DIV period.
            if (fading && fade_en)
                presc <= tick ? '0 : presc + PRESC_W'(1);
            else
                presc <= '0;

            if (!fade_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= UP;
                    UP: begin
                        if (any_press)
                            state <= HOLD;
                        else if (tick && (!can_up || duty_level == MAX_LVL - ONE))
                            state <= DOWN;
                    end
                    DOWN: begin
                        if (any_press)
                            state <= HOLD;
                        else if (tick && (!can_dn || duty_level == ONE))
                            state <= UP;
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end

`ifdef PWM_LOCAL_EN
    localparam int PER_W = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

    logic [PER_W-1:0] per_cnt;

    // Mod-MAX_LEVEL period counter; output high while counter < level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            per_cnt <= (per_cnt == PER_W'(MAX_LEVEL - 1)) ? '0 : per_cnt + PER_W'(1);
            pwm_out <= (LEVEL_W'(per_cnt) < duty_level);
        end
    end
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Directed bench for pwm_duty_controller (DEBOUNCE_CYCLES=4, FADE_DIV=4).
module tb_pwm_duty_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc_btn;
    logic       dec_btn;
    logic       fade_en;
    logic       step_up;
    logic       step_down;
    logic [3:0] duty_level;
    logic [1:0] fade_state;
    logic       pwm_out;

    int total = 0;
    int bad   = 0;
    int up_cnt = 0;
    int dn_cnt = 0;

    pwm_duty_controller #(
        .DEBOUNCE_CYCLES (4),
        .MAX_LEVEL       (10),
        .LEVEL_W         (4),
        .FADE_DIV        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_btn    (inc_btn),
        .dec_btn    (dec_btn),
        .fade_en    (fade_en),
        .step_up    (step_up),
        .step_down  (step_down),
        .duty_level (duty_level),
        .fade_state (fade_state),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    // Count step pulses between edges.
    always @(negedge clk) begin
        if (step_up === 1'b1)   up_cnt++;
        if (step_down === 1'b1) dn_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        fade_en = 1'b0;
        repeat (3) tk();
        rst_n = 1'b1;
    endtask

    // Hold button(s) through the debounce, check the step at latency 7,
    // release, then check exactly the expected number of pulses appeared.
    task automatic press(input string tag, input logic i, input logic d,
                         input int exp_up, input int exp_dn, input int exp_lvl);
        int u0, d0;
        u0 = up_cnt;
        d0 = dn_cnt;
        inc_btn = i;
        dec_btn = d;
        repeat (7) tk();
        chk({tag, "_up"},  int'(step_up), exp_up);
        chk({tag, "_dn"},  int'(step_down), exp_dn);
        chk({tag, "_lvl"}, int'(duty_level), exp_lvl);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        repeat (8) tk();
        chk({tag, "_nup"}, up_cnt - u0, exp_up);
        chk({tag, "_ndn"}, dn_cnt - d0, exp_dn);
    endtask

    task automatic pwm_win(input string tag, input int lvl);
        int h;
        int exp;
        h = 0;
        repeat (10) begin
            tk();
            h += int'(pwm_out);
        end
`ifdef PWM_LOCAL_EN
        exp = lvl;
`else
        exp = 0;
`endif
        chk(tag, h, exp);
    endtask

    initial begin
        int lvl;
        int u0;

        // Reset values, observed while reset is asserted.
        rst_n = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0; fade_en = 1'b0;
        repeat (2) tk();
        chk("rst_lvl",   int'(duty_level), 5);
        chk("rst_state", int'(fade_state), 0);
        chk("rst_up",    int'(step_up), 0);
        chk("rst_dn",    int'(step_down), 0);
        chk("rst_pwm",   int'(pwm_out), 0);
        rst_n = 1'b1;

        // Latency: step_up exactly on edge 7 after the first sampling edge.
        do_reset();
        u0 = up_cnt;
        inc_btn = 1'b1;
        repeat (6) tk();
        chk("lat_early", int'(step_up), 0);
        chk("lat_lvl5",  int'(duty_level), 5);
        tk();
        chk("lat_step",  int'(step_up), 1);
        chk("lat_lvl6",  int'(duty_level), 6);
        tk();
        chk("lat_pulse_end", int'(step_up), 0);
        inc_btn = 1'b0;
        repeat (10) tk();
        chk("lat_single", up_cnt - u0, 1);

        // Glitch of 3 sampled cycles is rejected.
        do_reset();
        u0 = up_cnt;
        inc_btn = 1'b1;
        repeat (3) tk();
        inc_btn = 1'b0;
        repeat (12) tk();
        chk("glitch_pulses", up_cnt - u0, 0);
        chk("glitch_lvl",    int'(duty_level), 5);

        // PWM at reset level.
        pwm_win("pwm_lvl5", 5);

        // Saturation up then down.
        do_reset();
        lvl = 5;
        for (int k = 1; k <= 7; k++) begin
            press($sformatf("inc%0d", k), 1'b1, 1'b0, (lvl < 10) ? 1 : 0, 0,
                  (lvl < 10) ? lvl + 1 : 10);
            if (lvl < 10) lvl++;
        end
        chk("sat_top", int'(duty_level), 10);
        pwm_win("pwm_lvl10", 10);
        for (int k = 1; k <= 11; k++) begin
            press($sformatf("dec%0d", k), 1'b0, 1'b1, 0, (lvl > 0) ? 1 : 0,
                  (lvl > 0) ? lvl - 1 : 0);
            if (lvl > 0) lvl--;
        end
        chk("sat_bot", int'(duty_level), 0);
        pwm_win("pwm_lvl0", 0);

        // Simultaneous presses cancel.
        do_reset();
        press("both", 1'b1, 1'b1, 0, 0, 5);

        // Fade ramp from level 5.
        do_reset();
        fade_en = 1'b1;
        tk();
        chk("fade_up_state", int'(fade_state), 1);
        for (int l = 6; l <= 10; l++) begin
            repeat (4) tk();
            chk($sformatf("ramp_up%0d", l), int'(duty_level), l);
            chk($sformatf("ramp_up%0d_s", l), int'(step_up), 1);
        end
        chk("fade_down_state", int'(fade_state), 2);
        for (int l = 9; l >= 0; l--) begin
            repeat (4) tk();
            chk($sformatf("ramp_dn%0d", l), int'(duty_level), l);
            chk($sformatf("ramp_dn%0d_s", l), int'(step_down), 1);
        end
        chk("fade_reup_state", int'(fade_state), 1);
        repeat (4) tk();
        chk("ramp_re1", int'(duty_level), 1);

        // Dec press mid-ramp: fade tick at +4 still lands, press at +7 holds.
        u0 = up_cnt;
        dec_btn = 1'b1;
        repeat (4) tk();
        chk("mid_lvl2", int'(duty_level), 2);
        repeat (3) tk();
        chk("hold_step",  int'(step_down), 1);
        chk("hold_lvl",   int'(duty_level), 1);
        chk("hold_state", int'(fade_state), 3);
        dec_btn = 1'b0;
        repeat (12) tk();
        chk("hold_stays", int'(fade_state), 3);
        chk("hold_lvl_kept", int'(duty_level), 1);
        fade_en = 1'b0;
        tk();
        chk("idle_state", int'(fade_state), 0);
        chk("idle_lvl",   int'(duty_level), 1);

        // Reset mid-fade with fade_en still high.
        fade_en = 1'b1;
        repeat (6) tk();
        rst_n = 1'b0;
        repeat (2) tk();
        chk("rstfade_state", int'(fade_state), 0);
        chk("rstfade_lvl",   int'(duty_level), 5);
        rst_n = 1'b1;
        tk();
        chk("rstfade_restart", int'(fade_state), 1);
        fade_en = 1'b0;
        tk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
